regfile_scoreboard: RTL and testbench

- Parametrised successor of the ID-stage register file: N read ports, one GPR write port, one 64-bit HI/LO write port, r0 hardwired to zero.
- Adds a per-register pending-write scoreboard (saturating counters) that drives per-port busy/stall flags to the hazard unit.
- Sits in ID: reads and issue-marking come from decode; writes and clears come from WB.

---
 rtl/regfile_scoreboard.sv | 222 ++++++++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// ID-stage register file with a pending-write scoreboard. It holds 31 usable
// GPRs (r0 is hardwired to zero) plus HI and LO. Each of these 33 registers has
// a small saturating counter of writes that decode has issued and WB has not
// yet retired. The counters drive the per-read-port busy flags used by the
// hazard unit. They also gate issue_ready_o, so a register never has more
// outstanding writes than its counter can hold.
//
// Address map (7 bits):
//   bit6 = 1          : HI when 7'h7F, LO for any other value
//   bit6 = 0, bit5 = 1: CP0 space, not stored, reads 0, never busy
//   otherwise         : GPR index in bits [4:0]; index 0 is r0
//
// Optional build macro REGFILE_WB_BYPASS_EN: when it is defined, a read that
// matches a same-cycle WB write gets the written data combinationally, and the
// busy flag of a register whose last pending write retires this cycle is
// suppressed.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   issue_valid_i  decode issues an instruction that writes issue_addr_i
//   issue_addr_i   destination of the issuing instruction
//   issue_hl_i     issuing instruction writes HI and LO (mult/div)
//   issue_ready_o  issue can be accepted this cycle
//   wr_en_i        WB writes wr_data_i to wr_addr_i
//   wr_addr_i      WB destination
//   wr_data_i      WB data
//   hl_wr_en_i     WB writes HI and LO
//   hl_wr_data_i   {HI, LO} write data
//   rd_addr_i      read addresses, port k uses [7k+6:7k]
//   rd_data_o      read data, port k uses its DATA_W slice
//   rd_busy_o      port k source still has a pending write
//   sb_err_o       sticky counter-underflow flag
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  input  logic [6:0]            issue_addr_i,
  input  logic                  issue_hl_i,
  output logic                  issue_ready_o,
  input  logic                  wr_en_i,
  input  logic [6:0]            wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  hl_wr_en_i,
  input  logic [2*DATA_W-1:0]   hl_wr_data_i,
  input  logic [NRD*7-1:0]      rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  output logic                  sb_err_o
);

  // Storage slots: 0..31 are GPRs (slot 0 is unused because r0 is never
  // written), 32 is HI and 33 is LO.
  localparam int          NREG = 34;
  localparam int          CW   = PEND_W + 2;
  localparam logic [5:0]  IDX_HI = 6'd32;
  localparam logic [5:0]  IDX_LO = 6'd33;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  // Convert an architectural address into {stored, slot}. CP0 addresses and
  // r0 come back as not stored, so every later rule ignores them.
  function automatic logic [6:0] decodeAddr(input logic [6:0] a);
    logic [6:0] r;
    r = '0;
    if (a[6]) begin
      r = (a == 7'h7F) ? {1'b1, IDX_HI} : {1'b1, IDX_LO};
    end else if (!a[5] && (a[4:0] != 5'd0)) begin
      r = {2'b10, a[4:0]};
    end
    return r;
  endfunction

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              sbErr_q;
  logic              sbErr_d;

  logic [6:0]      issueDec;
  logic [6:0]      wrDec;
  logic [6:0]      rdDec [NRD];
  logic            issueReady;
  logic [NREG-1:0] incVec;
  logic [NREG-1:0] decWr;
  logic [NREG-1:0] decHl;
  logic [CW-1:0]   sumExt;
  logic [CW-1:0]   decExt;
  logic [CW-1:0]   diffExt;

  // Issue acceptance and the per-slot increment/decrement requests. Issue is
  // refused when any targeted counter is already saturated. Because of this,
  // the increment can never overflow, even when a decrement arrives in the
  // same cycle.
  always_comb begin
    issueDec   = decodeAddr(issue_addr_i);
    wrDec      = decodeAddr(wr_addr_i);
    issueReady = 1'b1;
    if (issueDec[6] && (pend_q[issueDec[5:0]] == CNT_MAX)) begin
      issueReady = 1'b0;
    end
    if (issue_hl_i && ((pend_q[IDX_HI] == CNT_MAX) || (pend_q[IDX_LO] == CNT_MAX))) begin
      issueReady = 1'b0;
    end

    incVec = '0;
    if (issue_valid_i && issueReady) begin
      if (issueDec[6]) begin
        incVec[issueDec[5:0]] = 1'b1;
      end
      if (issue_hl_i) begin
        incVec[IDX_HI] = 1'b1;
        incVec[IDX_LO] = 1'b1;
      end
    end

    decWr = '0;
    if (wr_en_i && wrDec[6]) begin
      decWr[wrDec[5:0]] = 1'b1;
    end
    decHl         = '0;
    decHl[IDX_HI] = hl_wr_en_i;
    decHl[IDX_LO] = hl_wr_en_i;
  end

  // Counter next state. The single-port and HI/LO decrements are independent,
  // so a slot can drop by two in one cycle. The net change is applied in
  // widened arithmetic. Underflow clamps the counter at zero and latches the
  // sticky error.
  always_comb begin
    sbErr_d = sbErr_q;
    sumExt  = '0;
    decExt  = '0;
    diffExt = '0;
    for (int i = 0; i < NREG; i++) begin
      sumExt  = {2'b00, pend_q[i]} + CW'(incVec[i]);
      decExt  = CW'(decWr[i]) + CW'(decHl[i]);
      diffExt = sumExt - decExt;
      if (sumExt < decExt) begin
        pend_d[i] = '0;
        sbErr_d   = 1'b1;
      end else begin
        pend_d[i] = diffExt[PEND_W-1:0];
      end
    end
  end

  // Register data next state. A plain WB write to HI or LO updates only that
  // register. A same-cycle HI/LO write overrides it.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_i && wrDec[6]) begin
      regs_d[wrDec[5:0]] = wr_data_i;
    end
    if (hl_wr_en_i) begin
      regs_d[IDX_HI] = hl_wr_data_i[2*DATA_W-1:DATA_W];
      regs_d[IDX_LO] = hl_wr_data_i[DATA_W-1:0];
    end
  end

  // State registers. Reset drops all data and all pending-write state at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      sbErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        pend_q[i] <= pend_d[i];
      end
      sbErr_q <= sbErr_d;
    end
  end

  // Read ports. Unstored addresses (r0, CP0) read zero and are never busy.
  // With the bypass build, the read also picks up the WB value from this
  // cycle: the HI/LO slice wins over the single-port write.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rdDec[k] = decodeAddr(rd_addr_i[7*k +: 7]);
      if (rdDec[k][6]) begin
        rd_data_o[k*DATA_W +: DATA_W] = regs_q[rdDec[k][5:0]];
        rd_busy_o[k] = (pend_q[rdDec[k][5:0]] != '0);
`ifdef REGFILE_WB_BYPASS_EN
        if (hl_wr_en_i && (rdDec[k][5:0] == IDX_HI)) begin
          rd_data_o[k*DATA_W +: DATA_W] = hl_wr_data_i[2*DATA_W-1:DATA_W];
        end else if (hl_wr_en_i && (rdDec[k][5:0] == IDX_LO)) begin
          rd_data_o[k*DATA_W +: DATA_W] = hl_wr_data_i[DATA_W-1:0];
        end else if (wr_en_i && wrDec[6] && (wrDec[5:0] == rdDec[k][5:0])) begin
          rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
        end
        if ((pend_q[rdDec[k][5:0]] == CNT_ONE) &&
            (decWr[rdDec[k][5:0]] || decHl[rdDec[k][5:0]])) begin
          rd_busy_o[k] = 1'b0;
        end
`else
        rdDec[k] = rdDec[k];
`endif
      end
    end
  end

  assign issue_ready_o = issueReady;
  assign sb_err_o      = sbErr_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed scenarios (reset, RAW on r5, counter saturation, HI/LO, underflow,
// r0/CP0) followed by randomized traffic with a reset in the middle of the
// run. The expected values come from a behavioural model that keeps plain
// integer pending counts and register contents indexed by architectural
// register.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int NRD    = 2;
  localparam int PEND_W = 2;
  localparam int MAXC   = (1 << PEND_W) - 1;
  localparam int KHI    = 32;
  localparam int KLO    = 33;

  logic                  clk_i;
  logic                  rst_ni;
  logic                  issue_valid_i;
  logic [6:0]            issue_addr_i;
  logic                  issue_hl_i;
  logic                  issue_ready_o;
  logic                  wr_en_i;
  logic [6:0]            wr_addr_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  hl_wr_en_i;
  logic [2*DATA_W-1:0]   hl_wr_data_i;
  logic [NRD*7-1:0]      rd_addr_i;
  logic [NRD*DATA_W-1:0] rd_data_o;
  logic [NRD-1:0]        rd_busy_o;
  logic                  sb_err_o;

  int checks = 0;
  int errors = 0;

  // Reference state: pending write count and value per architectural register.
  int          cntM [34];
  logic [31:0] memM [34];
  bit          errM;

  regfile_scoreboard #(.DATA_W(DATA_W), .NRD(NRD), .PEND_W(PEND_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
    .issue_hl_i(issue_hl_i), .issue_ready_o(issue_ready_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .hl_wr_en_i(hl_wr_en_i), .hl_wr_data_i(hl_wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .sb_err_o(sb_err_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Architectural register of an address, or -1 when the address is not
  // stored (r0 and CP0 space).
  function automatic int keyOf(input logic [6:0] a);
    if (a[6]) return (a == 7'h7F) ? KHI : KLO;
    if (a[5]) return -1;
    if (a[4:0] == 5'd0) return -1;
    return int'(a[4:0]);
  endfunction

  function automatic bit expReady();
    int k;
    bit r;
    r = 1'b1;
    k = keyOf(issue_addr_i);
    if (k >= 0 && cntM[k] >= MAXC) r = 1'b0;
    if (issue_hl_i && (cntM[KHI] >= MAXC || cntM[KLO] >= MAXC)) r = 1'b0;
    return r;
  endfunction

  function automatic bit wbClears(input int key);
    if (key < 0) return 1'b0;
    if (hl_wr_en_i && (key == KHI || key == KLO)) return 1'b1;
    return wr_en_i && (keyOf(wr_addr_i) == key);
  endfunction

  function automatic logic [31:0] expData(input int key);
    if (key < 0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (hl_wr_en_i && key == KHI) return hl_wr_data_i[63:32];
    if (hl_wr_en_i && key == KLO) return hl_wr_data_i[31:0];
    if (wr_en_i && keyOf(wr_addr_i) == key) return wr_data_i;
`endif
    return memM[key];
  endfunction

  function automatic logic expBusy(input int key);
    if (key < 0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    if (cntM[key] == 1 && wbClears(key)) return 1'b0;
`endif
    return cntM[key] != 0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 34; i++) begin
      cntM[i] = 0;
      memM[i] = 32'h0;
    end
    errM = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic checkOutput();
    for (int k = 0; k < NRD; k++) begin
      int key;
      key = keyOf(rd_addr_i[7*k +: 7]);
      checkVal($sformatf("rd_data%0d", k), rd_data_o[k*DATA_W +: DATA_W], expData(key));
      checkVal($sformatf("rd_busy%0d", k), {31'b0, rd_busy_o[k]}, {31'b0, expBusy(key)});
    end
    checkVal("issue_ready", {31'b0, issue_ready_o}, {31'b0, expReady()});
    checkVal("sb_err", {31'b0, sb_err_o}, {31'b0, errM});
  endtask

  // Apply the spec's edge rules to the model, using the inputs held across
  // the edge: accepted issues add one to each distinct target, WB writes
  // subtract, and a negative result clamps at zero with the error latched.
  task automatic modelUpdate(input bit rdy);
    int delta [34];
    bit tgt [34];
    int k;
    int wk;
    if (!rst_ni) return;
    for (int i = 0; i < 34; i++) begin
      delta[i] = 0;
      tgt[i] = 1'b0;
    end
    if (issue_valid_i && rdy) begin
      k = keyOf(issue_addr_i);
      if (k >= 0) tgt[k] = 1'b1;
      if (issue_hl_i) begin
        tgt[KHI] = 1'b1;
        tgt[KLO] = 1'b1;
      end
    end
    for (int i = 0; i < 34; i++) if (tgt[i]) delta[i] += 1;
    wk = keyOf(wr_addr_i);
    if (wr_en_i && wk >= 0) delta[wk] -= 1;
    if (hl_wr_en_i) begin
      delta[KHI] -= 1;
      delta[KLO] -= 1;
    end
    for (int i = 0; i < 34; i++) begin
      cntM[i] += delta[i];
      if (cntM[i] < 0) begin
        cntM[i] = 0;
        errM = 1'b1;
      end
    end
    if (wr_en_i && wk >= 0) memM[wk] = wr_data_i;
    if (hl_wr_en_i) begin
      memM[KHI] = hl_wr_data_i[63:32];
      memM[KLO] = hl_wr_data_i[31:0];
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [6:0] ia, input logic ihl,
                               input logic we, input logic [6:0] wa, input logic [31:0] wd,
                               input logic hwe, input logic [63:0] hwd,
                               input logic [6:0] ra0, input logic [6:0] ra1);
    issue_valid_i = iv;
    issue_addr_i  = ia;
    issue_hl_i    = ihl;
    wr_en_i       = we;
    wr_addr_i     = wa;
    wr_data_i     = wd;
    hl_wr_en_i    = hwe;
    hl_wr_data_i  = hwd;
    rd_addr_i     = {ra1, ra0};
  endtask

  // Let the combinational outputs settle after the inputs change, then
  // compare them against the model.
  task automatic settle();
    #3;
    checkOutput();
  endtask

  // Advance to the next edge, update the model and leave the inputs just
  // after the edge.
  task automatic tick();
    bit rdy;
    rdy = expReady();
    @(posedge clk_i);
    modelUpdate(rdy);
    #1;
  endtask

  function automatic logic [6:0] randAddr();
    case ($urandom_range(0, 7))
      0: return 7'h00;
      1: return 7'h03;
      2: return 7'h05;
      3: return 7'h07;
      4: return 7'h25;
      5: return 7'h40;
      6: return 7'h7F;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    // Reset is asserted in the middle of a cycle and released later, away
    // from any clock edge.
    rst_ni = 1'b0;
    modelReset();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h05, 7'h7F);
    #12;
    checkOutput();
    #5 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    settle();
    checkVal("reset_rd0", rd_data_o[31:0], 32'h0);
    checkVal("reset_rd1", rd_data_o[63:32], 32'h0);
    checkVal("reset_busy", {30'b0, rd_busy_o}, 32'h0);
    checkVal("reset_ready", {31'b0, issue_ready_o}, 32'h1);
    checkVal("reset_err", {31'b0, sb_err_o}, 32'h0);
    tick();

    // r5 is issued, then written back two cycles later.
    applyStimulus(1, 7'h05, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h05, 7'h03);
    settle(); tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h05, 7'h03);
    settle();
    checkVal("r5_busy_after_issue", {31'b0, rd_busy_o[0]}, 32'h1);
    tick();
    applyStimulus(0, 7'h00, 0, 1, 7'h05, 32'hDEADBEEF, 0, 64'h0, 7'h05, 7'h03);
    settle();
`ifdef REGFILE_WB_BYPASS_EN
    checkVal("r5_bypass_data", rd_data_o[31:0], 32'hDEADBEEF);
    checkVal("r5_bypass_busy", {31'b0, rd_busy_o[0]}, 32'h0);
`else
    checkVal("r5_busy_wb_cycle", {31'b0, rd_busy_o[0]}, 32'h1);
`endif
    tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h05, 7'h03);
    settle();
    checkVal("r5_data", rd_data_o[31:0], 32'hDEADBEEF);
    checkVal("r5_free", {31'b0, rd_busy_o[0]}, 32'h0);
    tick();

    // r3 is issued until its counter saturates. The fourth issue is refused
    // until one write retires.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 7'h03, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h03, 7'h05);
      settle(); tick();
    end
    applyStimulus(1, 7'h03, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h03, 7'h05);
    settle();
    checkVal("r3_saturated_ready", {31'b0, issue_ready_o}, 32'h0);
    tick();
    applyStimulus(0, 7'h03, 0, 1, 7'h03, 32'h00000333, 0, 64'h0, 7'h03, 7'h05);
    settle(); tick();
    applyStimulus(0, 7'h03, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h03, 7'h05);
    settle();
    checkVal("r3_ready_after_wb", {31'b0, issue_ready_o}, 32'h1);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 7'h00, 0, 1, 7'h03, 32'h00000330 + i, 0, 64'h0, 7'h03, 7'h05);
      settle(); tick();
    end

    // HI/LO are issued together, then written together.
    applyStimulus(1, 7'h7F, 1, 0, 7'h00, 32'h0, 0, 64'h0, 7'h7F, 7'h40);
    settle(); tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h7F, 7'h40);
    settle();
    checkVal("hi_busy", {31'b0, rd_busy_o[0]}, 32'h1);
    checkVal("lo_busy", {31'b0, rd_busy_o[1]}, 32'h1);
    tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 1, 64'h11112222_33334444, 7'h7F, 7'h40);
    settle(); tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h7F, 7'h40);
    settle();
    checkVal("hi_data", rd_data_o[31:0], 32'h11112222);
    checkVal("lo_data", rd_data_o[63:32], 32'h33334444);
    checkVal("hilo_free", {30'b0, rd_busy_o}, 32'h0);
    tick();

    // A write to r7 while its counter is zero underflows. The error flag must
    // stay set afterwards.
    applyStimulus(0, 7'h00, 0, 1, 7'h07, 32'h00001234, 0, 64'h0, 7'h07, 7'h05);
    settle(); tick();
    applyStimulus(0, 7'h00, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h07, 7'h05);
    settle();
    checkVal("underflow_err", {31'b0, sb_err_o}, 32'h1);
    checkVal("underflow_busy", {31'b0, rd_busy_o[0]}, 32'h0);
    tick();
    settle();
    checkVal("underflow_sticky", {31'b0, sb_err_o}, 32'h1);
    tick();

    // Writes and issues to r0 and to CP0 space are ignored.
    applyStimulus(1, 7'h25, 0, 1, 7'h00, 32'hFFFFFFFF, 0, 64'h0, 7'h00, 7'h25);
    settle(); tick();
    applyStimulus(1, 7'h00, 0, 1, 7'h25, 32'hFFFFFFFF, 0, 64'h0, 7'h00, 7'h25);
    settle(); tick();
    applyStimulus(1, 7'h25, 0, 0, 7'h00, 32'h0, 0, 64'h0, 7'h00, 7'h25);
    settle();
    checkVal("r0_data", rd_data_o[31:0], 32'h0);
    checkVal("cp0_data", rd_data_o[63:32], 32'h0);
    checkVal("r0_cp0_busy", {30'b0, rd_busy_o}, 32'h0);
    checkVal("r0_cp0_ready", {31'b0, issue_ready_o}, 32'h1);
    tick();

    // Randomized traffic, with a reset asserted in the middle of a cycle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rst_ni = 1'b0;
        modelReset();
        settle();
        tick();
        rst_ni = 1'b1;
        #1;
      end
      applyStimulus(1'($urandom_range(0, 1)), randAddr(), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) != 0), randAddr(), $urandom(),
                    1'($urandom_range(0, 3) == 0), {$urandom(), $urandom()},
                    randAddr(), randAddr());
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
